// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code controller.
// Build option: PS2_TYPEMATIC_FILTER_EN enables auto-repeat suppression.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    SETTLE,
    EMIT,
    CLEAR
  } ps2_ctrl_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_key_tracker.sv
// Held-key tracker: drops make events that repeat the key still held.
// Only instantiated when PS2_TYPEMATIC_FILTER_EN is defined.
import ps2_pkg::*;

module ps2_key_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_check,
  input  logic [7:0] i_code,
  input  logic       i_ext,
  input  logic       i_brk,
  output logic       o_drop
);

  logic       r_held;
  logic [7:0] r_held_code;
  logic       r_held_ext;
  logic       w_match;

  assign w_match = r_held
                && (i_code == r_held_code)
                && (i_ext == r_held_ext);

  assign o_drop = i_check && !i_brk && w_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_held      <= 1'b0;
      r_held_code <= 8'h00;
      r_held_ext  <= 1'b0;
    end else if (i_check) begin
      if (!i_brk && !w_match) begin
        r_held      <= 1'b1;
        r_held_code <= i_code;
        r_held_ext  <= i_ext;
      end else if (i_brk && w_match) begin
        r_held <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 FIFO sequencer: pops bytes, folds E0/F0 prefixes into key events.
// Build option: PS2_TYPEMATIC_FILTER_EN drops auto-repeat makes.
import ps2_pkg::*;

module ps2_scancode_ctrl #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         kbd_data,
  input  logic               kbd_ready,
  input  logic               kbd_overflow,
  output logic               kbd_nextdata_n,
  output logic               kbd_clrn,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         evt_code,
  output logic               evt_ext,
  output logic               evt_brk,
  output logic [COUNT_W-1:0] key_count,
  output logic               ovf_sticky
);

  ps2_ctrl_state_t r_state;
  ps2_ctrl_state_t w_state_n;

  logic [7:0]         r_byte;
  logic               r_ext_f;
  logic               r_brk_f;
  ps2_evt_t           r_evt;
  logic               r_nextdata_n;
  logic               r_clrn;
  logic               r_evt_valid;
  logic [COUNT_W-1:0] r_count;
  logic               r_ovf;

  logic w_is_code;
  logic w_check;
  logic w_drop;
  logic w_latch;
  logic w_hs;

  assign w_is_code = (r_byte != PS2_PREFIX_EXT)
                  && (r_byte != PS2_PREFIX_BRK);
  assign w_check   = (r_state == POP) && w_is_code;
  assign w_latch   = (r_state == IDLE) && !kbd_overflow && kbd_ready;
  assign w_hs      = (r_state == EMIT) && evt_ready;

`ifdef PS2_TYPEMATIC_FILTER_EN
  ps2_key_tracker u_tracker (
    .clk     (clk),
    .reset   (reset),
    .i_check (w_check),
    .i_code  (r_byte),
    .i_ext   (r_ext_f),
    .i_brk   (r_brk_f),
    .o_drop  (w_drop)
  );
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: begin
        if (kbd_overflow)   w_state_n = CLEAR;
        else if (kbd_ready) w_state_n = POP;
      end
      POP: begin
        if (!w_is_code || w_drop) w_state_n = SETTLE;
        else                      w_state_n = EMIT;
      end
      SETTLE:  w_state_n = IDLE;
      EMIT:    if (evt_ready) w_state_n = IDLE;
      CLEAR:   w_state_n = SETTLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Strobes are registered from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte       <= 8'h00;
      r_ext_f      <= 1'b0;
      r_brk_f      <= 1'b0;
      r_evt        <= '0;
      r_nextdata_n <= 1'b1;
      r_clrn       <= 1'b0;
      r_evt_valid  <= 1'b0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_nextdata_n <= (w_state_n != POP);
      r_clrn       <= (w_state_n != CLEAR);
      r_evt_valid  <= (w_state_n == EMIT);
      if (w_state_n == CLEAR) r_ovf <= 1'b1;
      if (w_latch) r_byte <= kbd_data;
      if (r_state == POP) begin
        if (r_byte == PS2_PREFIX_EXT) begin
          r_ext_f <= 1'b1;
        end else if (r_byte == PS2_PREFIX_BRK) begin
          r_brk_f <= 1'b1;
        end else if (w_drop) begin
          r_ext_f <= 1'b0;
          r_brk_f <= 1'b0;
        end else begin
          r_evt.code <= r_byte;
          r_evt.ext  <= r_ext_f;
          r_evt.brk  <= r_brk_f;
        end
      end
      if (w_hs) begin
        r_ext_f <= 1'b0;
        r_brk_f <= 1'b0;
        if (!r_evt.brk) r_count <= r_count + COUNT_W'(1);
      end
      if (r_state == CLEAR) begin
        r_ext_f <= 1'b0;
        r_brk_f <= 1'b0;
      end
    end
  end

  assign kbd_nextdata_n = r_nextdata_n;
  assign kbd_clrn       = r_clrn;
  assign evt_valid      = r_evt_valid;
  assign evt_code       = r_evt.code;
  assign evt_ext        = r_evt.ext;
  assign evt_brk        = r_evt.brk;
  assign key_count      = r_count;
  assign ovf_sticky     = r_ovf;

endmodule

// File: doc/ps2_scancode_ctrl.md
# ps2_scancode_ctrl

Sequencing controller sitting between the `ps2_keyboard` receive FIFO and the display/consumer logic. It pops bytes from the FIFO with the `nextdata_n` handshake and recovers from FIFO overflow by pulsing `clrn`. It decodes PS/2 set-2 prefixes (E0 extended, F0 break) into single key events on a valid/ready interface and maintains a key-press counter for the seven-segment display path.

## Interface
- `COUNT_W`, default 8: width of `key_count`.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `kbd_data`  in  8  FIFO head byte from `ps2_keyboard`.
- `kbd_ready`  in  1  FIFO non-empty; `kbd_data` valid.
- `kbd_overflow`  in  1  FIFO overflow flag.
- `kbd_nextdata_n`  out  1  active-low pop strobe to FIFO.
- `kbd_clrn`  out  1  active-low FIFO clear.
- `evt_valid`  out  1  key event available.
- `evt_ready`  in  1  consumer accepts event.
- `evt_code`  out  8  scan code without prefixes.
- `evt_ext`  out  1  event was E0-prefixed.
- `evt_brk`  out  1  event is a break (release).
- `key_count`  out  COUNT_W  count of emitted make events.
- `ovf_sticky`  out  1  set on any FIFO overflow; cleared only by reset.

## Operation
- FSM states: IDLE, POP, SETTLE, EMIT, CLEAR.
- IDLE: `kbd_nextdata_n`=1.
  - If `kbd_overflow` is set, go to CLEAR. Overflow has priority over ready.
  - Else if `kbd_ready` is set, latch `kbd_data` into `byte_r` and go to POP.
- POP: `kbd_nextdata_n`=0 for exactly one cycle. Decode `byte_r`:
  - 0xE0: set `ext_f`, go to SETTLE.
  - 0xF0: set `brk_f`, go to SETTLE.
  - Otherwise: load `evt_code`=`byte_r`, `evt_ext`=`ext_f`, `evt_brk`=`brk_f`, and go to EMIT. If the filter drops the event, clear the flags and go to SETTLE instead.
- SETTLE: one cycle with `kbd_nextdata_n`=1, so the FIFO read pointer and `ready` update. Then go to IDLE.
- EMIT:
  - `evt_valid`=1. Event fields stay stable until `evt_ready`=1.
  - On handshake, clear `ext_f` and `brk_f`. If the event is a make, increment `key_count`. Go to IDLE.
  - No FIFO pop occurs while in EMIT. Backpressure stalls the FIFO.
- CLEAR:
  - `kbd_clrn`=0 for one cycle.
  - Clear `ext_f` and `brk_f`; a partial prefix sequence is discarded.
  - Set `ovf_sticky`. Go to SETTLE.
- `key_count` wraps modulo 2^COUNT_W (all-ones → 0). Break events never count.
- Consecutive prefixes accumulate: E0 F0 xx yields ext=1, brk=1. A repeated E0 or F0 is idempotent.
- Overflow rising while in EMIT: the pending event completes first. CLEAR follows from IDLE.

## Timing
- Reset values:
  - `kbd_nextdata_n`=1, `kbd_clrn`=0, `evt_valid`=0.
  - `evt_code`=0, `evt_ext`=0, `evt_brk`=0.
  - `key_count`=0, `ovf_sticky`=0. State is IDLE and flags are clear.
- `kbd_clrn` goes to 1 in the first cycle after reset deasserts.
- Let cycle T be the cycle where IDLE sees `kbd_ready`=1. Then `kbd_nextdata_n`=0 in T+1, and for a code byte `evt_valid`=1 from T+2.
- A prefix byte occupies 3 cycles (IDLE, POP, SETTLE).
- After a handshake in cycle H, `evt_valid`=0 in H+1. The next FIFO byte can be latched in H+1.
- Maximum throughput: one code byte per 3 cycles with `evt_ready` tied high.
- All outputs are registered. No combinational path from `evt_ready` to `kbd_nextdata_n`.
- Reset asserted mid-operation: all outputs take their reset values in the next cycle, and any in-flight event is dropped.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined:
  - Track the held key as code plus ext, with a `held` bit.
  - A make event matching the held key while `held`=1 is dropped: no emit and no count.
  - A make of a different key replaces the held key.
  - A break of the held key clears `held`. Break events are always emitted.
- Not defined: every make, including auto-repeat, is emitted and counted. The held-key registers are not generated.

## Structure
- Shared package `ps2_pkg`:
  - State enum `ps2_ctrl_state_t`.
  - Constants `PS2_PREFIX_EXT`=8'hE0 and `PS2_PREFIX_BRK`=8'hF0.
  - Struct `ps2_evt_t` containing code, ext and brk.
- Sub-module `ps2_key_tracker`: held-key registers and the drop decision. Instantiated only under `PS2_TYPEMATIC_FILTER_EN`.

## Test plan
- FIFO presents 0x1C with `evt_ready`=1 → `nextdata_n` low one cycle at T+1; event code=0x1C, ext=0, brk=0 at T+2; `key_count` 0→1.
- Bytes F0, 1C → single event code=0x1C, brk=1; `key_count` unchanged; two `nextdata_n` pulses.
- Bytes E0 75 then E0 F0 75 → event 0x75 ext=1 brk=0, then event 0x75 ext=1 brk=1; `key_count`=1.
- Bytes 1C 1C 1C F0 1C:
  - With the filter: one make and one break, `key_count`=1.
  - Without the filter: three makes and one break, `key_count`=3.
- Overflow raised after byte E0 → `kbd_clrn` low exactly one cycle; `ovf_sticky`=1; next byte 0x1C emits with ext=0.
- `evt_ready`=0 for 10 cycles with `kbd_ready`=1 → `evt_valid` held with stable fields and no pop. Reset asserted in the middle of this → `evt_valid`=0 and `key_count`=0 in the next cycle.
